hilo_muldiv_unit: RTL

Multi-cycle multiply/divide unit that owns the HI/LO register pair of the pipeline and serves them back to the datapath. The combinational ALU covers single-cycle ops. This block accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX, iterates for a fixed latency while stalling the pipeline, and holds HI/LO for MFHI/MFLO reads.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/hilo_muldiv_unit_if.sv | 16 +
 rtl/muldiv_step.sv | 21 ++
 rtl/hilo_muldiv_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int ITER_LAST = MD_WIDTH - 1;
  localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} md_state_e;
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between EX and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             md_start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;

  modport master (output md_start, md_op, md_a, md_b,
                  input  md_busy, md_done, hi_data, lo_data);
  modport slave  (input  md_start, md_op, md_a, md_b,
                  output md_busy, md_done, hi_data, lo_data);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring divide.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum, top, diff;

  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder shifted left with the next dividend bit; borrow means restore.
    top  = acc[2*WIDTH-1:WIDTH-1];
    diff = top - {1'b0, opnd};
    if (is_div)
      acc_nxt = diff[WIDTH] ? {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner with a fixed 35-cycle multiply/divide FSM.
// Signed MULT/DIV semantics are enabled by defining SIGNED_MULDIV_EN.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = MD_WIDTH) (
  input  logic clk,
  input  logic rst,
  hilo_muldiv_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic [WIDTH-1:0]   a_raw, b_raw, opnd, a_abs, b_abs, hi, lo;
  logic [2*WIDTH-1:0] acc, acc_nxt, fixed;
  logic               go, div0;

  assign go   = md.md_start && !md.md_op[2];
  assign div0 = op_div && (b_raw == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_RUN;
      S_RUN:   if (cnt == CW'(ITER_LAST)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SIGNED_MULDIV_EN
  logic op_sgn, neg_q, neg_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_sgn <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (state == S_IDLE && go) begin
      op_sgn <= md.md_op[0];
    end else if (state == S_PREP) begin
      neg_q <= op_sgn && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
      neg_r <= op_sgn && a_raw[WIDTH-1];
    end
  end

  always_comb begin
    a_abs = (op_sgn && a_raw[WIDTH-1]) ? -a_raw : a_raw;
    b_abs = (op_sgn && b_raw[WIDTH-1]) ? -b_raw : b_raw;
    fixed = acc;
    if (!op_div && neg_q) fixed = -acc;
    if (op_div && neg_q)  fixed[WIDTH-1:0] = -acc[WIDTH-1:0];
    if (op_div && neg_r)  fixed[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
  end
`else
  assign a_abs = a_raw;
  assign b_abs = b_raw;
  assign fixed = acc;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_div),
    .acc    (acc),
    .opnd   (opnd),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_div <= 1'b0;
      a_raw  <= '0;
      b_raw  <= '0;
      acc    <= '0;
      opnd   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (go) begin
          a_raw  <= md.md_a;
          b_raw  <= md.md_b;
          op_div <= md.md_op[1];
        end
        S_PREP: begin
          acc  <= {{WIDTH{1'b0}}, a_abs};
          opnd <= b_abs;
          cnt  <= '0;
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Divide by zero reports the caller's raw dividend, not its magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_IDLE && md.md_start && md.md_op == OP_MTHI) begin
      hi <= md.md_a;
    end else if (state == S_IDLE && md.md_start && md.md_op == OP_MTLO) begin
      lo <= md.md_a;
    end else if (state == S_FIX) begin
      hi <= div0 ? a_raw : fixed[2*WIDTH-1:WIDTH];
      lo <= div0 ? DIV0_LO : fixed[WIDTH-1:0];
    end
  end

  assign md.md_busy = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign md.md_done = (state == S_DONE);
  assign md.hi_data = hi;
  assign md.lo_data = lo;
endmodule
